// File: rtl/dyser_config_loader_pkg.sv
// Shared definitions for the dyser configuration loader: word geometry
// and FSM state encodings used by the loader and its shadow store.
package dyser_config_loader_pkg;

   localparam int CFG_WORD_W    = 21;
   localparam int CFG_NUM_WORDS = 17;
   localparam int CFG_CNT_W     = 5;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_LOAD  = 2'd1,
      CFG_APPLY = 2'd2
   } cfg_state_t;

   // True when a counter of cnt_w bits can index every word of a configuration.
   function automatic bit cnt_width_ok(input int cnt_w, input int num_words);
      return (1 << cnt_w) >= num_words;
   endfunction

endpackage

// File: rtl/dyser_cfg_shadow.sv
// Shadow store for an in-flight configuration: one indexed word write per
// cycle, asynchronous active-low reset, whole array presented flat.
module dyser_cfg_shadow
   import dyser_config_loader_pkg::*;
#(
   parameter int WORD_W    = CFG_WORD_W,
   parameter int NUM_WORDS = CFG_NUM_WORDS,
   parameter int CNT_W     = CFG_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [CNT_W-1:0]            wr_idx,
   input  logic [WORD_W-1:0]           wr_data,
   output logic [NUM_WORDS*WORD_W-1:0] shadow_flat
);

   // Write the addressed word; indices at or beyond NUM_WORDS are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: this array is built from flops, not RAM, so it is reset and its contents are defined from the first cycle.
         shadow_flat <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (wr_idx == CNT_W'(i)) begin
               shadow_flat[i*WORD_W +: WORD_W] <= wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/dyser_config_loader.sv
// Fabric-side receiver of the dyser configuration stream. Words are
// collected into a shadow store and, once a full set has arrived, copied
// atomically into the active configuration that steers switch/FU muxes.
// Optional feature: define DYSER_CFG_READBACK_EN to add a combinational
// read port (cfg_rd_idx/cfg_rd_data) onto the applied configuration.
module dyser_config_loader
   import dyser_config_loader_pkg::*;
#(
   parameter int WORD_W    = CFG_WORD_W,
   parameter int NUM_WORDS = CFG_NUM_WORDS,
   parameter int CNT_W     = CFG_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WORD_W-1:0]           config_bits,
   input  logic                        config_en,
   input  logic                        commit,
   output logic [NUM_WORDS*WORD_W-1:0] cfg_active,
   output logic                        cfg_valid,
   output logic                        cfg_busy,
   output logic                        cfg_ready,
   output logic                        cfg_flush,
   output logic                        cfg_err
`ifdef DYSER_CFG_READBACK_EN
   ,
   input  logic [CNT_W-1:0]            cfg_rd_idx,
   output logic [WORD_W-1:0]           cfg_rd_data
`endif
);

   cfg_state_t                  state;
   logic [CNT_W-1:0]            cnt;
   logic [NUM_WORDS*WORD_W-1:0] shadow_flat;
   logic                        last_word;
   logic                        shadow_wr;

   assign last_word = (cnt == CNT_W'(NUM_WORDS - 1));

   // A word lands in the shadow when idle (starting a load) or mid-load
   // without an abort; commit wins over a same-cycle word.
   assign shadow_wr = config_en &&
                      ((state == CFG_IDLE) || ((state == CFG_LOAD) && !commit));

   dyser_cfg_shadow #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .CNT_W     (CNT_W)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (shadow_wr),
      .wr_idx      (cnt),
      .wr_data     (config_bits),
      .shadow_flat (shadow_flat)
   );

   // Load FSM, word counter, sticky error and the active configuration register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= CFG_IDLE;
         cnt        <= '0;
         cfg_active <= '0;
         cfg_valid  <= 1'b0;
         cfg_busy   <= 1'b0;
         cfg_ready  <= 1'b1;
         cfg_flush  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         // NOTE: every flop here uses <= so all decisions see pre-edge values, and the outputs are registered alongside the state they describe.
         cfg_flush <= 1'b0;
         case (state)
            CFG_IDLE: begin
               if (config_en) begin
                  cnt      <= CNT_W'(1);
                  state    <= CFG_LOAD;
                  cfg_busy <= 1'b1;
               end
            end
            CFG_LOAD: begin
               if (commit) begin
                  cnt      <= '0;
                  state    <= CFG_IDLE;
                  cfg_busy <= 1'b0;
               end else if (config_en) begin
                  if (last_word) begin
                     cnt       <= '0;
                     state     <= CFG_APPLY;
                     cfg_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            CFG_APPLY: begin
               cfg_active <= shadow_flat;
               cfg_valid  <= 1'b1;
               cfg_flush  <= 1'b1;
               state      <= CFG_IDLE;
               cfg_busy   <= 1'b0;
               cfg_ready  <= 1'b1;
               if (config_en) begin
                  cfg_err <= 1'b1;
               end
            end
            default: begin
               state     <= CFG_IDLE;
               cnt       <= '0;
               cfg_busy  <= 1'b0;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef DYSER_CFG_READBACK_EN
   // Combinational read of one applied word; out-of-range indices read as zero.
   always_comb begin
      // NOTE: the default assignment first keeps this block free of inferred latches.
      cfg_rd_data = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (cfg_rd_idx == CNT_W'(i)) begin
            cfg_rd_data = cfg_active[i*WORD_W +: WORD_W];
         end
      end
   end
`endif

endmodule

// File: tb/tb_dyser_config_loader.sv
// Self-checking bench for dyser_config_loader. A small reference model
// (word array, expected active vector, valid/err flags) tracks what the
// applied configuration must be after each complete load.
module tb_dyser_config_loader;

   localparam int WORD_W    = 21;
   localparam int NUM_WORDS = 17;
   localparam int CNT_W     = 5;
   localparam int FLAT_W    = WORD_W * NUM_WORDS;

   logic              clk;
   logic              rst;
   logic [WORD_W-1:0] config_bits;
   logic              config_en;
   logic              commit;
   logic [FLAT_W-1:0] cfg_active;
   logic              cfg_valid;
   logic              cfg_busy;
   logic              cfg_ready;
   logic              cfg_flush;
   logic              cfg_err;
`ifdef DYSER_CFG_READBACK_EN
   logic [CNT_W-1:0]  cfg_rd_idx;
   logic [WORD_W-1:0] cfg_rd_data;
`endif

   int n_checks   = 0;
   int n_fail     = 0;
   int flush_seen = 0;

   logic [WORD_W-1:0] cfg_words [NUM_WORDS];
   logic [FLAT_W-1:0] exp_active;
   logic              exp_valid;
   logic              exp_err;

   dyser_config_loader dut (
      .clk         (clk),
      .rst         (rst),
      .config_bits (config_bits),
      .config_en   (config_en),
      .commit      (commit),
      .cfg_active  (cfg_active),
      .cfg_valid   (cfg_valid),
      .cfg_busy    (cfg_busy),
      .cfg_ready   (cfg_ready),
      .cfg_flush   (cfg_flush),
      .cfg_err     (cfg_err)
`ifdef DYSER_CFG_READBACK_EN
      ,
      .cfg_rd_idx  (cfg_rd_idx),
      .cfg_rd_data (cfg_rd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FLAT_W-1:0] obs,
                        input logic [FLAT_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cfg_flush === 1'b1) flush_seen++;
   endtask

   function automatic logic [FLAT_W-1:0] pack_words();
      logic [FLAT_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_WORDS; i++) p[i*WORD_W +: WORD_W] = cfg_words[i];
      return p;
   endfunction

   task automatic randomize_words();
      for (int i = 0; i < NUM_WORDS; i++) cfg_words[i] = WORD_W'($urandom);
   endtask

   // Send words first..last, with a random idle gap of gmin..gmax cycles between words.
   task automatic send_words(input int first, input int last, input int gmin, input int gmax);
      for (int i = first; i <= last; i++) begin
         if (i > first) begin
            config_en = 1'b0;
            repeat ($urandom_range(gmax, gmin)) begin
               tick();
               check("gap_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b1));
            end
         end
         config_en   = 1'b1;
         config_bits = cfg_words[i];
         tick();
         config_en = 1'b0;
         check("load_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b1));
         check("load_active_held", cfg_active, exp_active);
         check("load_valid_held", FLAT_W'(cfg_valid), FLAT_W'(exp_valid));
         if (i != NUM_WORDS - 1) check("load_ready", FLAT_W'(cfg_ready), FLAT_W'(1'b1));
      end
   endtask

   // Called in the APPLY cycle (right after the last word's edge).
   task automatic finish_apply(input bit poke, input bit cmt);
      int idx;
      check("apply_ready", FLAT_W'(cfg_ready), FLAT_W'(1'b0));
      check("apply_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b1));
      check("apply_flush_early", FLAT_W'(cfg_flush), FLAT_W'(1'b0));
      check("apply_active_old", cfg_active, exp_active);
      config_en   = poke;
      commit      = cmt;
      config_bits = WORD_W'($urandom);
      tick();
      config_en = 1'b0;
      commit    = 1'b0;
      exp_active = pack_words();
      exp_valid  = 1'b1;
      if (poke) exp_err = 1'b1;
      check("post_flush", FLAT_W'(cfg_flush), FLAT_W'(1'b1));
      check("post_active", cfg_active, exp_active);
      check("post_valid", FLAT_W'(cfg_valid), FLAT_W'(1'b1));
      check("post_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      check("post_ready", FLAT_W'(cfg_ready), FLAT_W'(1'b1));
      check("post_err", FLAT_W'(cfg_err), FLAT_W'(exp_err));
`ifdef DYSER_CFG_READBACK_EN
      idx = $urandom_range(NUM_WORDS - 1, 0);
      cfg_rd_idx = CNT_W'(idx);
      #1;
      check("rd_in_range", FLAT_W'(cfg_rd_data), FLAT_W'(cfg_words[idx]));
      cfg_rd_idx = CNT_W'($urandom_range(31, NUM_WORDS));
      #1;
      check("rd_out_of_range", FLAT_W'(cfg_rd_data), FLAT_W'(0));
`else
      idx = 0;
`endif
      tick();
      check("flush_one_cycle", FLAT_W'(cfg_flush), FLAT_W'(1'b0));
      check("idle_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      check("flush_count", FLAT_W'(flush_seen), FLAT_W'(1));
   endtask

   initial begin
      logic [FLAT_W-1:0] saved_active;

      rst         = 1'b0;
      config_en   = 1'b0;
      commit      = 1'b0;
      config_bits = '0;
`ifdef DYSER_CFG_READBACK_EN
      cfg_rd_idx  = '0;
`endif
      exp_active  = '0;
      exp_valid   = 1'b0;
      exp_err     = 1'b0;

      // 1: reset held for two cycles
      repeat (2) tick();
      check("rst_active", cfg_active, FLAT_W'(0));
      check("rst_valid", FLAT_W'(cfg_valid), FLAT_W'(1'b0));
      check("rst_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      check("rst_ready", FLAT_W'(cfg_ready), FLAT_W'(1'b1));
      check("rst_err", FLAT_W'(cfg_err), FLAT_W'(1'b0));
      check("rst_flush", FLAT_W'(cfg_flush), FLAT_W'(1'b0));
      rst = 1'b1;
      tick();

      // 2: full back-to-back load with the directed words in place
      randomize_words();
      cfg_words[2]  = 21'h000800;
      cfg_words[7]  = 21'h080444;
      cfg_words[13] = 21'h100000;
      cfg_words[14] = 21'h050009;
      flush_seen = 0;
      send_words(0, NUM_WORDS - 1, 0, 0);
      finish_apply(1'b0, 1'b0);
      check("t2_word7", FLAT_W'(cfg_active[7*WORD_W +: WORD_W]), FLAT_W'(21'h080444));
`ifdef DYSER_CFG_READBACK_EN
      cfg_rd_idx = CNT_W'(7);
      #1;
      check("t2_rd_word7", FLAT_W'(cfg_rd_data), FLAT_W'(21'h080444));
`endif

      // 3: same words with 3 idle cycles between words; commit during APPLY is ignored
      flush_seen = 0;
      send_words(0, NUM_WORDS - 1, 3, 3);
      finish_apply(1'b0, 1'b1);

      // 4: abort after 5 words; the same-cycle word is dropped without error
      saved_active = exp_active;
      randomize_words();
      send_words(0, 4, 0, 2);
      commit      = 1'b1;
      config_en   = 1'b1;
      config_bits = WORD_W'($urandom);
      tick();
      commit    = 1'b0;
      config_en = 1'b0;
      check("abort_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      check("abort_active", cfg_active, saved_active);
      check("abort_valid", FLAT_W'(cfg_valid), FLAT_W'(1'b1));
      check("abort_err", FLAT_W'(cfg_err), FLAT_W'(1'b0));
      tick();
      check("abort_still_idle", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      // commit in IDLE has no effect: the accompanying word starts a fresh load
      randomize_words();
      flush_seen  = 0;
      commit      = 1'b1;
      config_en   = 1'b1;
      config_bits = cfg_words[0];
      tick();
      commit    = 1'b0;
      config_en = 1'b0;
      check("idle_commit_starts", FLAT_W'(cfg_busy), FLAT_W'(1'b1));
      send_words(1, NUM_WORDS - 1, 0, 3);
      finish_apply(1'b0, 1'b0);

      // 5: config_en during APPLY is dropped and raises the sticky error
      randomize_words();
      flush_seen = 0;
      send_words(0, NUM_WORDS - 1, 0, 1);
      finish_apply(1'b1, 1'b0);
      repeat (3) tick();
      check("err_sticky", FLAT_W'(cfg_err), FLAT_W'(1'b1));
      check("err_active", cfg_active, exp_active);

      // 6: config A of all ones, then reset partway through config B
      for (int i = 0; i < NUM_WORDS; i++) cfg_words[i] = 21'h1FFFFF;
      flush_seen = 0;
      send_words(0, NUM_WORDS - 1, 0, 2);
      finish_apply(1'b0, 1'b0);
      randomize_words();
      send_words(0, 9, 0, 2);
      #2;
      rst = 1'b0;
      #1;
      exp_active = '0;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
      check("rst_mid_active", cfg_active, FLAT_W'(0));
      check("rst_mid_valid", FLAT_W'(cfg_valid), FLAT_W'(1'b0));
      check("rst_mid_busy", FLAT_W'(cfg_busy), FLAT_W'(1'b0));
      check("rst_mid_err", FLAT_W'(cfg_err), FLAT_W'(1'b0));
      check("rst_mid_ready", FLAT_W'(cfg_ready), FLAT_W'(1'b1));
      tick();
      rst = 1'b1;
      tick();
      // a load after reset must start from word 0 again
      randomize_words();
      flush_seen = 0;
      send_words(0, NUM_WORDS - 1, 0, 2);
      finish_apply(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
